// File: rtl/hdb3_rx_ctrl.sv
// HDB3 receive controller: tracks mark polarity, erases 000V/B00V substitutions through a
// 4-symbol delay line, sequences IDLE/ACQ/LOCK/LOS link state and counts code violations.
module hdb3_rx_ctrl #(
    parameter int LOCK_MARKS = 4,
    parameter int LOS_ZEROS  = 16,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 indata_P,
    input  logic                 indata_N,
    input  logic                 clr_err,
    output logic                 dataout,
    output logic                 dataout_valid,
    output logic                 locked,
    output logic                 los,
    output logic                 code_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int ZW = $clog2(LOS_ZEROS + 1);
    localparam int MW = $clog2(LOCK_MARKS + 1);

    localparam logic [ZW-1:0] Z_LOS  = ZW'(LOS_ZEROS);
    localparam logic [ZW-1:0] Z_TWO  = ZW'(2);
    localparam logic [ZW-1:0] Z_FOUR = ZW'(4);
    localparam logic [MW-1:0] M_LOCK = MW'(LOCK_MARKS);
    localparam logic [MW-1:0] M_ONE  = MW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2,
        ST_LOS  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      d;
    logic [ZW-1:0]   zrun;
    logic [ZW-1:0]   zrun_nxt;
    logic [MW-1:0]   mcnt;
    logic [MW-1:0]   mcnt_nxt;
    logic            last_pol;
    logic            first_mark;
    logic            v_seen;
    logic            last_v_pol;

    logic            mark_pos;
    logic            mark_neg;
    logic            illegal;
    logic            is_mark;
    logic            pol;
    logic            is_v;
    logic            v_bad_zeros;
    logic            v_bad_pol;
    logic            zero_four;
    logic            viol;
    logic            err_now;
    logic            los_entry;

    assign mark_pos = indata_P & ~indata_N;
    assign mark_neg = ~indata_P & indata_N;
    assign illegal  = indata_P & indata_N;
    assign is_mark  = mark_pos | mark_neg;
    assign pol      = mark_pos;

    // A mark repeating the previous mark's polarity is a bipolar violation (V).
    assign is_v = is_mark & ~first_mark & (pol == last_pol);

    always_comb begin
        zrun_nxt = zrun;
        if (is_mark) begin
            zrun_nxt = '0;
        end else if (zrun != Z_LOS) begin
            zrun_nxt = zrun + 1'b1;
        end
    end

    // The zero-run count doubles as the history of the two preceding symbols.
    assign v_bad_zeros = is_v & (zrun < Z_TWO);
    assign v_bad_pol   = is_v & v_seen & (pol == last_v_pol);
    assign zero_four   = (state == ST_LOCK) & ~is_mark & (zrun_nxt == Z_FOUR) & (zrun != Z_FOUR);
    assign viol        = illegal | v_bad_zeros | v_bad_pol | zero_four;
    assign err_now     = en & (state != ST_LOS) & viol;

    // The first strobe out of IDLE is already an acquisition symbol.
    always_comb begin
        state_nxt = state;
        mcnt_nxt  = mcnt;
        if (en) begin
            case (state)
                ST_IDLE, ST_ACQ: begin
                    if (viol) begin
                        mcnt_nxt = '0;
                    end else if (is_mark) begin
                        mcnt_nxt = mcnt + 1'b1;
                    end
                    state_nxt = ST_ACQ;
                    if (zrun_nxt == Z_LOS) begin
                        state_nxt = ST_LOS;
                    end else if (!viol && is_mark && (mcnt_nxt == M_LOCK)) begin
                        state_nxt = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (zrun_nxt == Z_LOS) begin
                        state_nxt = ST_LOS;
                    end
                end
                ST_LOS: begin
                    if (is_mark) begin
                        state_nxt = ST_ACQ;
                        mcnt_nxt  = M_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
            if ((state != ST_LOS) && (state_nxt == ST_LOS)) begin
                mcnt_nxt = '0;
            end
        end
    end

    assign los_entry = en & (state != ST_LOS) & (state_nxt == ST_LOS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mcnt   <= '0;
            zrun   <= '0;
            locked <= 1'b0;
            los    <= 1'b0;
        end else if (en) begin
            state  <= state_nxt;
            mcnt   <= mcnt_nxt;
            zrun   <= zrun_nxt;
            locked <= (state_nxt == ST_LOCK);
            los    <= (state_nxt == ST_LOS);
        end
    end

    // LOS entry forgets polarity history so the first mark after it can never read as V.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pol   <= 1'b0;
            first_mark <= 1'b1;
            v_seen     <= 1'b0;
            last_v_pol <= 1'b0;
        end else if (en) begin
            if (is_mark) begin
                last_pol   <= pol;
                first_mark <= 1'b0;
            end
            if (is_v) begin
                v_seen     <= 1'b1;
                last_v_pol <= pol;
            end
            if (los_entry) begin
                first_mark <= 1'b1;
                v_seen     <= 1'b0;
            end
        end
    end

    // On V, the V and the three symbols behind it (000 or B00) are replaced with zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d       <= '0;
            dataout <= 1'b0;
        end else if (en) begin
            dataout <= d[3];
            if (los_entry || is_v) begin
                d <= '0;
            end else begin
                d <= {d[2:0], is_mark};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout_valid <= 1'b0;
            code_err      <= 1'b0;
        end else begin
            dataout_valid <= en & (state == ST_LOCK);
            code_err      <= err_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (err_now && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
